// File: rtl/ext_mem_pkg.sv
// ext_mem_pkg
// Shared definitions for the ext_mem responder:
//   - ADDR_W / DATA_W : request address and data widths
//   - CNT_W           : width of the wait-cycle counter (LATENCY 0..15)
//   - state_t         : responder FSM states IDLE / WAIT / DONE
package ext_mem_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/ext_mem_array.sv
// ext_mem_array
// Single-port synchronous RAM. The read port is registered and reads the
// addressed word every cycle. Contents have no defined power-up value and
// are never cleared.
// Ports:
//   clk    - clock
//   we     - write enable, commits wdata to addr on the rising edge
//   addr   - word index
//   wdata  - write data
//   rdata  - registered read data (old contents when we is high)
module ext_mem_array
  import ext_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/ext_mem_resp.sv
// ext_mem_resp
// Responder end of the ext_mem request/ready handshake, backed by a
// DEPTH_WORDS x 32 on-chip RAM. A request (read or write level) seen in
// IDLE is latched, LATENCY wait cycles are spent in WAIT, and the RAM
// access happens on the edge entering DONE. The registered ready pulse
// (and read data) appear in the cycle after DONE, giving ready in the
// cycle after edge N+1+LATENCY for a request first seen at edge N.
// Optional feature macro: EXT_MEM_RESP_ERR_EN adds the ext_mem_err port,
// pulsed with ready for read+write collisions or out-of-range addresses.
// Ports:
//   clk           - clock, rising edge
//   rst           - synchronous active-high reset
//   ext_mem_addr  - byte address (bits [1:0] ignored, high bits alias)
//   ext_mem_wdata - write data
//   ext_mem_write - write request level (wins over read)
//   ext_mem_read  - read request level
//   ext_mem_rdata - registered read data, held until the next read
//   ext_mem_ready - registered one-cycle completion pulse
//   ext_mem_err   - registered error pulse (EXT_MEM_RESP_ERR_EN only)
module ext_mem_resp
  import ext_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ext_mem_addr,
  input  logic [DATA_W-1:0] ext_mem_wdata,
  input  logic              ext_mem_write,
  input  logic              ext_mem_read,
  output logic [DATA_W-1:0] ext_mem_rdata,
  output logic              ext_mem_ready
`ifdef EXT_MEM_RESP_ERR_EN
  ,
  output logic              ext_mem_err
`endif
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  // First byte-address bit above the word index; anything set from here up aliases.
  localparam int TAG_LO = IDX_W + 2;
  localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(LATENCY);

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [DATA_W-1:0] wdata_reg, wdata_next;
  logic              write_reg, write_next;
  logic [DATA_W-1:0] rdata_reg;
  logic              ready_reg;

  logic              req;
  logic              entering_done;
  logic              ram_we;
  logic [IDX_W-1:0]  ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              unused_addr_bits;

  assign req = ext_mem_read | ext_mem_write;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    write_next = write_reg;
    case (state_reg)
      IDLE: begin
        if (req) begin
          addr_next  = ext_mem_addr;
          wdata_next = ext_mem_wdata;
          // Read and write together is a write; the read is dropped.
          write_next = ext_mem_write;
          cnt_next   = LAT_INIT;
          state_next = (LATENCY == 0) ? DONE : WAIT;
        end
      end
      WAIT: begin
        cnt_next = cnt_reg - CNT_W'(1);
        if (cnt_reg == CNT_W'(1)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // The RAM sees the transaction on the edge entering DONE. Using the
  // *_next values lets LATENCY=0 go straight from IDLE with the live inputs.
  // Gating with rst aborts a pending write when reset lands in WAIT.
  assign entering_done = !rst && (state_next == DONE) && (state_reg != DONE);
  assign ram_we        = entering_done && write_next;
  assign ram_addr      = addr_next[IDX_W+1:2];
  assign ram_wdata     = wdata_next;

  assign unused_addr_bits = (^addr_next[1:0]) ^ (^(addr_next >> TAG_LO));

  ext_mem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      rdata_reg <= '0;
      ready_reg <= 1'b0;
      write_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      write_reg <= write_next;
      // DONE lasts one cycle, so ready can never be high twice in a row.
      ready_reg <= (state_reg == DONE);
      // RAM output during DONE is the word read on the edge entering DONE.
      if ((state_reg == DONE) && !write_reg) begin
        rdata_reg <= ram_rdata;
      end
    end
  end

  // Address and data are only meaningful while a transaction is pending.
  always_ff @(posedge clk) begin
    addr_reg  <= addr_next;
    wdata_reg <= wdata_next;
  end

  assign ext_mem_rdata = rdata_reg;
  assign ext_mem_ready = ready_reg;

`ifdef EXT_MEM_RESP_ERR_EN
  logic bad_reg;
  logic err_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      bad_reg <= 1'b0;
      err_reg <= 1'b0;
    end else begin
      if ((state_reg == IDLE) && req) begin
        bad_reg <= (ext_mem_read & ext_mem_write) |
                   ((ext_mem_addr >> TAG_LO) != '0);
      end
      err_reg <= (state_reg == DONE) && bad_reg;
    end
  end

  assign ext_mem_err = err_reg;
`endif

endmodule

// File: tb/tb_ext_mem_resp.sv
module tb_ext_mem_resp;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr0, addr1;
  logic [31:0] wdata0, wdata1, rdata0, rdata1;
  logic        wr0, rd0, wr1, rd1, ready0, ready1;
`ifdef EXT_MEM_RESP_ERR_EN
  logic        err0, err1;
`endif

  always #5 clk = ~clk;

  ext_mem_resp #(.DEPTH_WORDS(1024), .LATENCY(2)) dut0 (
    .clk           (clk),
    .rst           (rst),
    .ext_mem_addr  (addr0),
    .ext_mem_wdata (wdata0),
    .ext_mem_write (wr0),
    .ext_mem_read  (rd0),
    .ext_mem_rdata (rdata0),
    .ext_mem_ready (ready0)
`ifdef EXT_MEM_RESP_ERR_EN
    ,
    .ext_mem_err   (err0)
`endif
  );

  ext_mem_resp #(.DEPTH_WORDS(1024), .LATENCY(0)) dut1 (
    .clk           (clk),
    .rst           (rst),
    .ext_mem_addr  (addr1),
    .ext_mem_wdata (wdata1),
    .ext_mem_write (wr1),
    .ext_mem_read  (rd1),
    .ext_mem_rdata (rdata1),
    .ext_mem_ready (ready1)
`ifdef EXT_MEM_RESP_ERR_EN
    ,
    .ext_mem_err   (err1)
`endif
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] rdata;
    bit          err;
    int          lat;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    bit          wr;
    bit          rd;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    bit          exp_err;
  } vec_t;
  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Ready must never be high in two consecutive cycles on either responder.
  bit prev0 = 1'b0, prev1 = 1'b0;
  always @(negedge clk) begin
    if (ready0) check("dut0 ready back-to-back", {31'b0, prev0}, 32'h0);
    if (ready1) check("dut1 ready back-to-back", {31'b0, prev1}, 32'h0);
    prev0 = ready0;
    prev1 = ready1;
  end

  // One request on dut0 (LATENCY=2): push expectation, drive, wait for ready, pop and compare.
  task automatic txn0(input bit w, input bit r, input logic [15:0] a, input logic [31:0] d,
                      input logic [31:0] exp_rd, input bit exp_err, input string name);
    exp_t e;
    int   cyc;
    e.rdata = exp_rd;
    e.err   = exp_err;
    e.lat   = 4;
    sb_q.push_back(e);
    @(negedge clk);
    wr0 = w; rd0 = r; addr0 = a; wdata0 = d;
    cyc = 0;
    do begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end while (!ready0 && cyc < 40);
    wr0 = 1'b0; rd0 = 1'b0;
    e = sb_q.pop_front();
    $display("[TB] txn %s w=%0d r=%0d addr=%h rdata=%h cycles=%0d", name, w, r, a, rdata0, cyc);
    check({name, " latency"}, cyc, e.lat);
    check({name, " rdata"}, rdata0, e.rdata);
`ifdef EXT_MEM_RESP_ERR_EN
    check({name, " err"}, {31'b0, err0}, {31'b0, e.err});
`endif
  endtask

  // Count ready pulses on a responder over n cycles; the caller expects none.
  task automatic quiet(input int n, input bit which, input string name);
    int hits;
    hits = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      if ((which == 1'b0) ? ready0 : ready1) hits++;
    end
    check({name, " no ready"}, hits, 32'd0);
  endtask

  initial begin
    int cyc;
    rst = 1'b1;
    wr0 = 0; rd0 = 0; addr0 = '0; wdata0 = '0;
    wr1 = 0; rd1 = 0; addr1 = '0; wdata1 = '0;

    vecs[0]  = '{1, 0, 16'h0010, 32'hDEADBEEF, 32'h00000000, 0};
    vecs[1]  = '{0, 1, 16'h0010, 32'h0,        32'hDEADBEEF, 0};
    vecs[2]  = '{1, 0, 16'h0008, 32'h11112222, 32'hDEADBEEF, 0};
    vecs[3]  = '{0, 1, 16'h0009, 32'h0,        32'h11112222, 0};
    vecs[4]  = '{1, 0, 16'h0004, 32'h55AA55AA, 32'h11112222, 0};
    vecs[5]  = '{1, 1, 16'h0004, 32'hA5A5A5A5, 32'h11112222, 1};
    vecs[6]  = '{0, 1, 16'h0004, 32'h0,        32'hA5A5A5A5, 0};
    vecs[7]  = '{1, 0, 16'h1000, 32'h00000001, 32'hA5A5A5A5, 1};
    vecs[8]  = '{0, 1, 16'h0000, 32'h0,        32'h00000001, 0};
    vecs[9]  = '{1, 0, 16'h0FFC, 32'hCAFEF00D, 32'h00000001, 0};
    vecs[10] = '{0, 1, 16'h0FFE, 32'h0,        32'hCAFEF00D, 0};
    vecs[11] = '{0, 1, 16'h8010, 32'h0,        32'hDEADBEEF, 1};
    vecs[12] = '{0, 1, 16'h0008, 32'h0,        32'h11112222, 0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset ready0", {31'b0, ready0}, 32'h0);
    check("reset rdata0", rdata0, 32'h0);
    check("reset ready1", {31'b0, ready1}, 32'h0);
    check("reset rdata1", rdata1, 32'h0);
`ifdef EXT_MEM_RESP_ERR_EN
    check("reset err0", {31'b0, err0}, 32'h0);
`endif

    for (int i = 0; i < 13; i++) begin
      txn0(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata,
           vecs[i].exp_rdata, vecs[i].exp_err, $sformatf("vec%0d", i));
    end

    // Reset while a write sits in WAIT: no commit, no ready, rdata cleared.
    txn0(1, 0, 16'h0020, 32'h0BADF00D, 32'h11112222, 0, "w20 old");
    @(negedge clk);
    wr0 = 1'b1; addr0 = 16'h0020; wdata0 = 32'h12345678;
    @(posedge clk);
    @(negedge clk);
    check("wait ready", {31'b0, ready0}, 32'h0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; wr0 = 1'b0;
    $display("[TB] txn rst-in-wait addr=0020 rdata=%h", rdata0);
    check("rst-in-wait ready", {31'b0, ready0}, 32'h0);
    check("rst-in-wait rdata", rdata0, 32'h0);
    quiet(6, 1'b0, "rst-in-wait");
    txn0(0, 1, 16'h0020, 32'h0, 32'h0BADF00D, 0, "r20 after abort");

    // Reset while a read sits in DONE: the ready pulse is dropped.
    @(negedge clk);
    rd0 = 1'b1; addr0 = 16'h0010;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b1; rd0 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    $display("[TB] txn rst-in-done addr=0010 ready=%0d rdata=%h", ready0, rdata0);
    check("rst-in-done ready", {31'b0, ready0}, 32'h0);
    check("rst-in-done rdata", rdata0, 32'h0);
    quiet(4, 1'b0, "rst-in-done");

    // Requests present only at a reset edge are ignored by both responders.
    @(negedge clk);
    rst = 1'b1; rd0 = 1'b1; addr0 = 16'h0010; rd1 = 1'b1; addr1 = 16'h0010;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; rd0 = 1'b0; rd1 = 1'b0;
    $display("[TB] txn req-at-reset ready0=%0d ready1=%0d", ready0, ready1);
    quiet(6, 1'b0, "req-at-reset dut0");
    quiet(2, 1'b1, "req-at-reset dut1");

    // LATENCY=0: write, then a read held continuously starting right after ready.
    @(negedge clk);
    wr1 = 1'b1; addr1 = 16'h0040; wdata1 = 32'h77665544;
    cyc = 0;
    do begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end while (!ready1 && cyc < 40);
    wr1 = 1'b0; rd1 = 1'b1;
    $display("[TB] txn l0 write addr=0040 cycles=%0d", cyc);
    check("l0 write latency", cyc, 32'd2);
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      @(negedge clk);
      $display("[TB] txn l0 hold-read k=%0d ready=%0d rdata=%h", k, ready1, rdata1);
      check($sformatf("l0 ready k%0d", k), {31'b0, ready1}, {31'b0, (k % 2 == 0)});
      if (k % 2 == 0) check($sformatf("l0 rdata k%0d", k), rdata1, 32'h77665544);
    end
    rd1 = 1'b0;
    quiet(4, 1'b1, "l0 after drop");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Absolute guard so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
